// File: rtl/div_seq_32_if.sv
// div_seq_32_if: request/result bundle for the sequential 32-bit divider.
//   master side (requester): drives start, signed_op, dividend, divisor;
//                            observes busy, done, quo, rem, div_zero.
//   slave side (divider)   : the reverse directions.
interface div_seq_32_if;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quo, rem, div_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quo, rem, div_zero
  );
endinterface

// File: rtl/div_seq_32.sv
// div_seq_32: sequential restoring divider for MIPS DIV/DIVU.
//   clk_i   : rising-edge clock
//   rst_n_i : synchronous active-low reset
//   bus     : div_seq_32_if.slave
//             start/signed_op/dividend/divisor in,
//             busy/done/quo(LO)/rem(HI)/div_zero out
// One quotient bit is produced per clock by a single shared subtractor.
// A normal result appears 34 clocks after the accepting edge; a zero
// divisor short-circuits to a result one clock after acceptance.

// subtract_32_bit: a_i - b_i; cout_o = 1 means no borrow (a_i >= b_i).
module subtract_32_bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] diff_o,
  output logic        cout_o
);
  logic [32:0] sum;

  assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
  assign diff_o = sum[31:0];
  assign cout_o = sum[32];
endmodule

module div_seq_32 #(
  parameter int ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  div_seq_32_if.slave bus
);
  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

  state_t      state_q;
  logic [31:0] dvd_q;      // raw dividend (needed for div-by-zero rem and signs)
  logic [31:0] dvs_q;      // raw divisor, replaced by its magnitude in PREP
  logic        sgn_q;
  logic [31:0] r_q;        // partial remainder
  logic [31:0] q_q;        // shifts out dividend bits, shifts in quotient bits
  logic [CW-1:0] cnt_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic        dz_q;

  logic [31:0] trial_d;
  logic [31:0] sub_diff;
  logic        sub_cout;
  logic [31:0] r_d;
  logic [31:0] q_d;

  // Two's complement negate: invert and add one.
  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  // Magnitude of a signed operand; 0x80000000 maps to itself, read unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic s);
    logic [31:0] m;
    if (s && x[31]) begin
      m = neg32(x);
    end else begin
      m = x;
    end
    return m;
  endfunction

  subtract_32_bit u_sub (
    .a_i    (trial_d),
    .b_i    (dvs_q),
    .diff_o (sub_diff),
    .cout_o (sub_cout)
  );

  // One restoring step. The bit shifted out of R is the 33rd trial bit, so
  // when R[31] is set the trial is >= 2^32 and always exceeds the divisor;
  // the 32-bit difference is then still the correct new remainder.
  always_comb begin
    trial_d = {r_q[30:0], q_q[31]};
    r_d     = trial_d;
    q_d     = {q_q[30:0], 1'b0};
    if (sub_cout || r_q[31]) begin
      r_d = sub_diff;
      q_d = {q_q[30:0], 1'b1};
    end else begin
      r_d = trial_d;
      q_d = {q_q[30:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      sgn_q     <= 1'b0;
      r_q       <= 32'd0;
      q_q       <= 32'd0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dz_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            dvd_q   <= bus.dividend;
            dvs_q   <= bus.divisor;
            sgn_q   <= bus.signed_op;
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PREP: begin
          if (dvs_q == 32'd0) begin
            quo_q   <= 32'hFFFF_FFFF;
            rem_q   <= dvd_q;
            dz_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            r_q       <= 32'd0;
            q_q       <= mag32(dvd_q, sgn_q);
            dvs_q     <= mag32(dvs_q, sgn_q);
            neg_quo_q <= sgn_q & (dvd_q[31] ^ dvs_q[31]);
            neg_rem_q <= sgn_q & dvd_q[31];
            cnt_q     <= '0;
            state_q   <= S_ITER;
          end
        end
        S_ITER: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + ONE;
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_ITER;
          end
        end
        S_FIX: begin
          quo_q   <= neg_quo_q ? neg32(q_q) : q_q;
          rem_q   <= neg_rem_q ? neg32(r_q) : r_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.quo      = quo_q;
  assign bus.rem      = rem_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_div_seq_32.sv
// tb_div_seq_32: directed bench for div_seq_32 with a cycle-level
// reference model (integer arithmetic plus completion timing) checked
// on every clock, and literal expectations after each operation.
module tb_div_seq_32;
  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  div_seq_32_if bus_if ();

  div_seq_32 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Model state written by the driver
  int          accept_seq = 0;
  int          n_edge = 0;
  int          m_lat = 0;
  logic [31:0] m_q = 32'd0;
  logic [31:0] m_r = 32'd0;
  logic        m_dz = 1'b0;
  // Model state written by the checker
  int          done_seq = 0;
  logic [31:0] h_q = 32'd0;
  logic [31:0] h_r = 32'd0;
  logic        h_dz = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics with plain integer arithmetic.
  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output int lat);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
    end else if (!s) begin
      q = a / b; r = a % b; dz = 1'b0; lat = 34;
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0]; r = lr[31:0]; dz = 1'b0; lat = 34;
    end
  endtask

  // Per-cycle compare: expected busy/done timing and held result outputs.
  always @(posedge clk) begin
    logic pend, e_busy, e_done;
    #1;
    pend = (accept_seq != done_seq);
    if (!rst_n) begin
      e_busy = 1'b0; e_done = 1'b0;
      done_seq = accept_seq;
      h_q = 32'd0; h_r = 32'd0; h_dz = 1'b0;
    end else begin
      e_busy = pend && (cyc >= n_edge) && (cyc < n_edge + m_lat);
      e_done = pend && (cyc == n_edge + m_lat);
      if (pend && cyc == n_edge) h_dz = 1'b0;
      if (e_done) begin
        h_q = m_q; h_r = m_r; h_dz = m_dz;
        done_seq = accept_seq;
      end
    end
    chk("busy", {31'd0, bus_if.busy}, {31'd0, e_busy});
    chk("done", {31'd0, bus_if.done}, {31'd0, e_done});
    chk("quo", bus_if.quo, h_q);
    chk("rem", bus_if.rem, h_r);
    chk("div_zero", {31'd0, bus_if.div_zero}, {31'd0, h_dz});
  end

  // Raise start now (call at a negedge); model records it only if idle.
  task automatic start_now(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    logic dz;
    int lat;
    bus_if.signed_op = s;
    bus_if.dividend  = a;
    bus_if.divisor   = b;
    bus_if.start     = 1'b1;
    if (accept_seq == done_seq) begin
      model(s, a, b, q, r, dz, lat);
      m_q = q; m_r = r; m_dz = dz; m_lat = lat;
      n_edge = cyc + 1;
      accept_seq++;
    end
  endtask

  task automatic release_start();
    @(negedge clk);
    bus_if.start     = 1'b0;
    bus_if.signed_op = 1'b1;
    bus_if.dividend  = 32'hDEAD_BEEF;
    bus_if.divisor   = 32'h1357_9BDF;
  endtask

  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_now(s, a, b);
    release_start();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      if (accept_seq == done_seq) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a, b, q, r;
    logic        dz;
  } vec_t;
  vec_t vecs[12];

  initial begin
    logic [31:0] q, r;
    logic dz;
    int lat;
    int k;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'h0000_0001, 1'b0};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'h8000_0000,  32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[5]  = '{1'b0, 32'h1234_5678,  32'h0000_0000,  32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
    vecs[6]  = '{1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'h0000_0002, 1'b0};
    vecs[7]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'h0000_0007,  32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0000,  32'h0000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'h0000_0003,  32'h2AAA_AAAA, 32'h0000_0002, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0000,  32'h0000_0002,  32'hC000_0000, 32'h0000_0000, 1'b0};

    rst_n = 1'b0;
    bus_if.start = 1'b0;
    bus_if.signed_op = 1'b0;
    bus_if.dividend = 32'd0;
    bus_if.divisor = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_quo", bus_if.quo, 32'd0);
    chk("reset_busy", {31'd0, bus_if.busy}, 32'd0);
    rst_n = 1'b1;

    // Directed vectors: model pinned to literals, DUT checked against literals.
    for (int i = 0; i < 12; i++) begin
      model(vecs[i].s, vecs[i].a, vecs[i].b, q, r, dz, lat);
      chk($sformatf("model_q[%0d]", i), q, vecs[i].q);
      chk($sformatf("model_r[%0d]", i), r, vecs[i].r);
      do_op(vecs[i].s, vecs[i].a, vecs[i].b);
      wait_done();
      chk($sformatf("vec_quo[%0d]", i), bus_if.quo, vecs[i].q);
      chk($sformatf("vec_rem[%0d]", i), bus_if.rem, vecs[i].r);
      chk($sformatf("vec_dz[%0d]", i), {31'd0, bus_if.div_zero}, {31'd0, vecs[i].dz});
    end

    // Latency: done must be seen exactly 34 edges after acceptance.
    do_op(1'b0, 32'd100, 32'd7);
    k = n_edge;
    while (cyc < k + 34) @(negedge clk);
    chk("lat_done_n34", {31'd0, bus_if.done}, 32'd1);
    // Back-to-back: start while done is high.
    start_now(1'b0, 32'd9, 32'd3);
    release_start();
    wait_done();
    chk("b2b_quo", bus_if.quo, 32'd3);
    chk("b2b_rem", bus_if.rem, 32'd0);

    // Start during an operation is ignored.
    do_op(1'b0, 32'd1000, 32'd10);
    repeat (8) @(negedge clk);
    start_now(1'b1, 32'd5, 32'd0);
    release_start();
    wait_done();
    chk("ign_quo", bus_if.quo, 32'd100);
    chk("ign_rem", bus_if.rem, 32'd0);
    chk("ign_dz", {31'd0, bus_if.div_zero}, 32'd0);

    // Reset mid-operation abandons it: no done, outputs cleared.
    do_op(1'b0, 32'd77, 32'd3);
    repeat (18) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_quo", bus_if.quo, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_quo", bus_if.quo, 32'd0);
    chk("post_rst_rem", bus_if.rem, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
